// File: rtl/mdv_fetch_sched.sv
// mdv_fetch_sched: fetches a microdrive cartridge image from SDRAM one 16-bit word at a time and
// streams it to the microdrive byte engine as bytes, looping at the end of the image.
//
// Ports:
//   clk, reset           core clock, synchronous active-high reset
//   enable               tape motor running; gates new reads
//   img_len              image length in bytes (sampled continuously)
//   mem_ena, video_cycle SDRAM slot availability; reads only in free non-video slots
//   mem_addr, mem_read   word read request (byte address, always even; one-cycle strobe)
//   mem_din              read data, valid RD_LAT cycles after the strobe
//   byte_req             consumer pops one byte
//   byte_out, byte_valid head byte of the prefetch FIFO and its valid flag
//   underrun             sticky flag: pop attempted with nothing buffered
//   wrapped              pulses in the capture cycle when the fetch address wraps to BASE
module mdv_fetch_sched #(
    parameter logic [24:0] BASE   = 25'h0400000,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned RD_LAT = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [24:0] img_len,
    input  logic        mem_ena,
    input  logic        video_cycle,
    output logic [24:0] mem_addr,
    output logic        mem_read,
    input  logic [15:0] mem_din,
    input  logic        byte_req,
    output logic [7:0]  byte_out,
    output logic        byte_valid,
    output logic        underrun,
    output logic        wrapped
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH + 1);
    localparam logic [CntW-1:0] DepthC = CntW'(DEPTH);
    localparam logic [2:0] RdLatC = 3'(RD_LAT);

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait
    } state_e;

    state_e          state_q, state_d;
    logic [24:0]     mem_addr_q, mem_addr_d;
    logic [2:0]      lat_cnt_q, lat_cnt_d;
    logic [15:0]     fifo_q [DEPTH];
    logic [15:0]     fifo_d [DEPTH];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            phase_lo_q, phase_lo_d;
    logic            underrun_q, underrun_d;

    logic            len_ok;
    logic            fetch_ok;
    logic            slot_ok;
    logic            has_data;
    logic            capture;
    logic            pop_byte;
    logic            pop_word;
    logic            wrap_hit;
    logic [25:0]     next_addr;
    logic [25:0]     wrap_limit;
    logic [15:0]     head_word;

    always_comb begin
        len_ok     = (img_len >= 25'd2);
        fetch_ok   = enable && len_ok;
        slot_ok    = mem_ena && !video_cycle;
        has_data   = (count_q != '0);
        capture    = (state_q == StWait) && (lat_cnt_q == RdLatC);
        pop_byte   = byte_req && has_data;
        pop_word   = pop_byte && phase_lo_q;
        // 26-bit sums so BASE+img_len cannot overflow the compare. Comparing the even next
        // address against the raw length means an odd image still fetches its last byte.
        next_addr  = {1'b0, mem_addr_q} + 26'd2;
        wrap_limit = {1'b0, BASE} + {1'b0, img_len};
        wrap_hit   = (next_addr >= wrap_limit);
        head_word  = fifo_q[rd_ptr_q];
    end

    // Prefetch FIFO and byte phase
    always_comb begin
        fifo_d     = fifo_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        phase_lo_d = phase_lo_q;
        underrun_d = underrun_q;

        if (capture) begin
            fifo_d[wr_ptr_q] = mem_din;
            wr_ptr_d         = wr_ptr_q + PtrW'(1);
        end

        if (pop_byte) begin
            phase_lo_d = !phase_lo_q;
        end
        if (pop_word) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        if (byte_req && !has_data) begin
            underrun_d = 1'b1;
        end

        if (capture && !pop_word) begin
            count_d = count_q + CntW'(1);
        end else if (!capture && pop_word) begin
            count_d = count_q - CntW'(1);
        end
    end

    // Read sequencer. count_d already reflects this cycle's capture and pop, so the
    // WAIT->ISSUE shortcut sees the occupancy the next read will land in.
    always_comb begin
        state_d    = state_q;
        mem_addr_d = mem_addr_q;
        lat_cnt_d  = lat_cnt_q;

        unique case (state_q)
            StIdle: begin
                if (fetch_ok && (count_d < DepthC)) begin
                    state_d = StIssue;
                end
            end
            StIssue: begin
                if (!fetch_ok) begin
                    state_d = StIdle;
                end else if (slot_ok) begin
                    state_d   = StWait;
                    lat_cnt_d = 3'd1;
                end
            end
            StWait: begin
                if (capture) begin
                    mem_addr_d = wrap_hit ? BASE : next_addr[24:0];
                    state_d    = (fetch_ok && (count_d < DepthC)) ? StIssue : StIdle;
                end else begin
                    lat_cnt_d = lat_cnt_q + 3'd1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            mem_addr_q <= BASE;
            lat_cnt_q  <= 3'd0;
            fifo_q     <= '{default: '0};
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            phase_lo_q <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            mem_addr_q <= mem_addr_d;
            lat_cnt_q  <= lat_cnt_d;
            fifo_q     <= fifo_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            phase_lo_q <= phase_lo_d;
            underrun_q <= underrun_d;
        end
    end

    // The strobe must land in the very slot it was granted, so it is decoded from the
    // registered state and the live slot inputs rather than registered itself.
    assign mem_read   = (state_q == StIssue) && fetch_ok && slot_ok;
    assign mem_addr   = mem_addr_q;
    assign byte_valid = has_data;
    assign byte_out   = !has_data ? 8'h00 : (phase_lo_q ? head_word[7:0] : head_word[15:8]);
    assign underrun   = underrun_q;
    assign wrapped    = capture && wrap_hit;

endmodule

// File: tb/tb_mdv_fetch_sched.sv
// tb_mdv_fetch_sched: scoreboard bench for mdv_fetch_sched. A memory model answers each strobe
// with word = address[15:0] after RD_LAT cycles (random junk otherwise). The reference model
// views the image as a byte tape: byte p of the tape comes from word BASE+2*(p/2). The monitor
// checks strobe slots/addresses, wrap pulse timing and every popped byte.
module tb_mdv_fetch_sched;

    localparam logic [24:0] BASE   = 25'h0435A6C;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned RD_LAT = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [24:0] img_len;
    logic        mem_ena;
    logic        video_cycle;
    logic [24:0] mem_addr;
    logic        mem_read;
    logic [15:0] mem_din;
    logic        byte_req;
    logic [7:0]  byte_out;
    logic        byte_valid;
    logic        underrun;
    logic        wrapped;

    always #5 clk = ~clk;

    mdv_fetch_sched #(
        .BASE  (BASE),
        .DEPTH (DEPTH),
        .RD_LAT(RD_LAT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .img_len    (img_len),
        .mem_ena    (mem_ena),
        .video_cycle(video_cycle),
        .mem_addr   (mem_addr),
        .mem_read   (mem_read),
        .mem_din    (mem_din),
        .byte_req   (byte_req),
        .byte_out   (byte_out),
        .byte_valid (byte_valid),
        .underrun   (underrun),
        .wrapped    (wrapped)
    );

    // Memory model: fixed-latency pipeline, junk on the bus when no read is due.
    logic [16:0] rd_pipe [RD_LAT];
    logic [15:0] junk;
    always @(posedge clk) begin
        rd_pipe[0] <= {mem_read, mem_addr[15:0]};
        for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
        junk <= 16'($urandom);
    end
    assign mem_din = (rd_pipe[RD_LAT-1][16] === 1'b1) ? rd_pipe[RD_LAT-1][15:0] : junk;

    int         checks = 0;
    int         failures = 0;
    int         cyc = 0;
    int         strobes = 0;
    int         wraps_seen = 0;
    int         cur_len = 16;
    int         tape_pos = 0;
    int         widx = 0;
    logic [7:0] exp_q [$];
    int         wrap_due [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [7:0] tape_byte(input int pos);
        logic [24:0] wa;
        logic [15:0] w;
        wa = BASE + 25'((pos / 2) * 2);
        w  = wa[15:0];
        return ((pos % 2) != 0) ? w[7:0] : w[15:8];
    endfunction

    // Monitor / scoreboard
    initial begin
        logic       exp_w;
        logic [7:0] e;
        forever begin
            @(negedge clk);
            cyc++;
            if (reset) begin
                widx = 0;
                wrap_due.delete();
            end else begin
                exp_w = (wrap_due.size() > 0) && (wrap_due[0] == cyc);
                if (exp_w) void'(wrap_due.pop_front());
                if (wrapped || exp_w) check("wrapped", 32'(wrapped), 32'(exp_w));
                if (wrapped) wraps_seen++;
                if (mem_read) begin
                    strobes++;
                    check("slot_free", 32'({mem_ena, video_cycle}), 32'h2);
                    check("rd_addr", 32'(mem_addr), 32'(BASE + 25'(2 * widx)));
                    widx++;
                    if (widx >= (cur_len + 1) / 2) begin
                        widx = 0;
                        wrap_due.push_back(cyc + RD_LAT);
                    end
                end
                if (byte_req && byte_valid) begin
                    if (exp_q.size() == 0) begin
                        check("sb_nonempty", 32'(exp_q.size()), 32'd1);
                    end else begin
                        e = exp_q.pop_front();
                        check("byte_out", 32'(byte_out), 32'(e));
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int len);
        reset       = 1'b1;
        enable      = 1'b0;
        byte_req    = 1'b0;
        mem_ena     = 1'b1;
        video_cycle = 1'b0;
        img_len     = 25'(len);
        cur_len     = len;
        tick();
        tick();
        reset      = 1'b0;
        tape_pos   = 0;
        strobes    = 0;
        wraps_seen = 0;
        exp_q.delete();
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_mem_read"}, 32'(mem_read), 32'd0);
        check({tag, "_mem_addr"}, 32'(mem_addr), 32'(BASE));
        check({tag, "_byte_valid"}, 32'(byte_valid), 32'd0);
        check({tag, "_byte_out"}, 32'(byte_out), 32'd0);
        check({tag, "_underrun"}, 32'(underrun), 32'd0);
        check({tag, "_wrapped"}, 32'(wrapped), 32'd0);
    endtask

    task automatic pop_one();
        int n = 0;
        while (!byte_valid && n < 200) begin
            tick();
            n++;
        end
        if (!byte_valid) begin
            check("pop_timeout", 32'(byte_valid), 32'd1);
        end else begin
            exp_q.push_back(tape_byte(tape_pos));
            tape_pos = (tape_pos + 1) % cur_len;
            byte_req = 1'b1;
            tick();
            byte_req = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        // Fill to DEPTH, first-byte latency, then stream through a wrap.
        do_reset(16);
        check_reset_vals("rst");
        enable = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!mem_read && n < 50);
        check("first_strobe", 32'(mem_read), 32'd1);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!byte_valid && n < 50);
        check("valid_latency", 32'(n), 32'(RD_LAT + 1));
        tick();
        repeat (40) tick();
        check("strobes_full", 32'(strobes), 32'(DEPTH));
        check("valid_full", 32'(byte_valid), 32'd1);
        for (int i = 0; i < 17; i++) pop_one();
        repeat (10) tick();
        check("wrap_seen", 32'(wraps_seen > 0), 32'd1);

        // Underrun on empty FIFO, then a normal fetch.
        do_reset(16);
        byte_req = 1'b1;
        tick();
        byte_req = 1'b0;
        check("underrun_set", 32'(underrun), 32'd1);
        check("underrun_empty", 32'(byte_valid), 32'd0);
        repeat (5) tick();
        check("underrun_sticky", 32'(underrun), 32'd1);
        enable = 1'b1;
        for (int i = 0; i < 4; i++) pop_one();
        check("underrun_kept", 32'(underrun), 32'd1);

        // img_len < 2: nothing is fetched.
        do_reset(1);
        enable = 1'b1;
        repeat (20) tick();
        check("short_no_strobe", 32'(strobes), 32'd0);
        check("short_addr_held", 32'(mem_addr), 32'(BASE));

        // Drop enable during the third read; it still lands, then resume in place.
        do_reset(16);
        enable = 1'b1;
        n = 0;
        while (strobes < 3 && n < 100) begin
            tick();
            n++;
        end
        enable = 1'b0;
        repeat (20) tick();
        check("drop_strobes", 32'(strobes), 32'd3);
        for (int i = 0; i < 6; i++) pop_one();
        check("drop_three_words", 32'(byte_valid), 32'd0);
        enable = 1'b1;
        for (int i = 0; i < 4; i++) pop_one();
        check("resume_strobes", 32'(strobes > 3), 32'd1);

        // Reset while a read is in flight; the late data must be ignored.
        do_reset(16);
        enable = 1'b1;
        n = 0;
        while (strobes < 1 && n < 100) begin
            tick();
            n++;
        end
        reset = 1'b1;
        tick();
        reset    = 1'b0;
        enable   = 1'b0;
        tape_pos = 0;
        strobes  = 0;
        exp_q.delete();
        check_reset_vals("midrst");
        repeat (6) tick();
        check("stale_dropped", 32'(byte_valid), 32'd0);
        enable = 1'b1;
        for (int i = 0; i < 4; i++) pop_one();

        // Randomized slots, pops and motor gating; alternating video first, then random.
        do_reset(20);
        enable = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            mem_ena     = ($urandom_range(0, 3) != 0);
            video_cycle = (c < 1500) ? 1'(c % 2) : 1'($urandom_range(0, 1));
            if (c % 97 == 0) enable = ($urandom_range(0, 3) != 0);
            if (byte_valid && ($urandom_range(0, 1) != 0)) begin
                exp_q.push_back(tape_byte(tape_pos));
                tape_pos = (tape_pos + 1) % cur_len;
                byte_req = 1'b1;
            end else begin
                byte_req = 1'b0;
            end
            tick();
        end
        byte_req    = 1'b0;
        enable      = 1'b0;
        video_cycle = 1'b0;
        repeat (10) tick();
        n = 0;
        while (byte_valid && n < 40) begin
            pop_one();
            n++;
        end
        check("drained", 32'(byte_valid), 32'd0);
        check("rand_wraps", 32'(wraps_seen > 0), 32'd1);
        check("wraps_pending", 32'(wrap_due.size()), 32'd0);
        check("underrun_clean", 32'(underrun), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
